// File: rtl/init_arb_pkg.sv
// init_arb_pkg: shared payload width Y, ctrl mux codes and arbiter FSM states
package init_arb_pkg;
  localparam int Y = 8;
  localparam logic [1:0] CTRL_IDLE = 2'b00;
  localparam logic [1:0] CTRL_CH1 = 2'b01;
  localparam logic [1:0] CTRL_CH2 = 2'b10;
  typedef enum logic [1:0] {IDLE, SEND, CHECK, DROP} state_t;
endpackage

// File: rtl/init_arb_if.sv
// init_arb_if: bus of init_arb (in1/in2 valid/data/ready offers, ctrl/chan1/chan2 mux outputs, err in, fault/busy status)
interface init_arb_if;
  import init_arb_pkg::*;
  logic in1_valid, in1_ready, in2_valid, in2_ready, err, fault, busy;
  logic [Y-1:0] in1_data, in2_data, chan1, chan2;
  logic [1:0] ctrl;
  modport master (
    output in1_valid, in1_data, in2_valid, in2_data, err,
    input in1_ready, in2_ready, ctrl, chan1, chan2, fault, busy
  );
  modport slave (
    input in1_valid, in1_data, in2_valid, in2_data, err,
    output in1_ready, in2_ready, ctrl, chan1, chan2, fault, busy
  );
endinterface

// File: rtl/init_fifo2.sv
// init_fifo2: 2-entry FIFO with registered ready (c, rst_n, wr_valid/wr_data/wr_ready push side, pop/head/not_empty read side)
module init_fifo2 import init_arb_pkg::*; (
  input  logic         c,
  input  logic         rst_n,
  input  logic         wr_valid,
  input  logic [Y-1:0] wr_data,
  output logic         wr_ready,
  input  logic         pop,
  output logic [Y-1:0] head,
  output logic         not_empty
);
  logic [Y-1:0] mem [2];
  logic wp, rp, push;
  logic [1:0] cnt, cnt_nx;
  assign push = wr_valid && wr_ready;
  assign cnt_nx = cnt + {1'b0, push} - {1'b0, pop};
  assign head = mem[rp];
  assign not_empty = cnt != 2'd0;
  always_ff @(posedge c or negedge rst_n)
    if (!rst_n) begin
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
      wr_ready <= 1'b0;
    end else begin
      wp <= wp ^ push;
      rp <= rp ^ pop;
      cnt <= cnt_nx;
      wr_ready <= cnt_nx < 2'd2;
    end
  always_ff @(posedge c)
    if (push) mem[wp] <= wr_data;
endmodule

// File: rtl/init_arb.sv
// init_arb: round-robin two-source arbiter with per-entry retry/drop (c, rst_n, bus: init_arb_if.slave)
module init_arb import init_arb_pkg::*; #(
  parameter int MAX_RETRY = 3
) (
  input logic      c,
  input logic      rst_n,
  init_arb_if.slave bus
);
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);
  state_t st, st_nx;
  logic gnt, gnt_nx, last, last_nx, done, ne1, ne2, pop1, pop2;
  logic [RW-1:0] rty, rty_nx;
  logic [Y-1:0] head1, head2;
  init_fifo2 u_f1 (
    .c(c), .rst_n(rst_n), .wr_valid(bus.in1_valid), .wr_data(bus.in1_data), .wr_ready(bus.in1_ready),
    .pop(pop1), .head(head1), .not_empty(ne1)
  );
  init_fifo2 u_f2 (
    .c(c), .rst_n(rst_n), .wr_valid(bus.in2_valid), .wr_data(bus.in2_data), .wr_ready(bus.in2_ready),
    .pop(pop2), .head(head2), .not_empty(ne2)
  );
  always_comb begin
    done = st == DROP || (st == CHECK && !bus.err);
    gnt_nx = st == IDLE ? (ne1 && ne2 ? !last : ne2) : gnt;
    st_nx = st == IDLE ? (ne1 || ne2 ? SEND : IDLE) :
            st == SEND ? CHECK :
            st == CHECK ? (!bus.err ? IDLE : rty < RMAX ? SEND : DROP) : IDLE;
    rty_nx = done ? '0 : (st == CHECK && bus.err && rty < RMAX) ? rty + 1'b1 : rty;
    last_nx = done ? gnt : last;
    pop1 = done && !gnt;
    pop2 = done && gnt;
    bus.ctrl = (st == SEND || st == CHECK) ? (gnt ? CTRL_CH2 : CTRL_CH1) : CTRL_IDLE;
    bus.fault = st == DROP;
    bus.busy = st != IDLE;
  end
  always_ff @(posedge c or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      gnt <= 1'b0;
      last <= 1'b1;
      rty <= '0;
      bus.chan1 <= '0;
      bus.chan2 <= '0;
    end else begin
      st <= st_nx;
      gnt <= gnt_nx;
      last <= last_nx;
      rty <= rty_nx;
      if (st_nx == SEND && !gnt_nx) bus.chan1 <= head1;
      if (st_nx == SEND && gnt_nx) bus.chan2 <= head2;
    end
endmodule

// File: tb/tb_init_arb.sv
// tb_init_arb: directed and random stimulus for init_arb checked against a queue-based reference model
module tb_init_arb;
  import init_arb_pkg::*;
  localparam int MR = 3;
  logic c = 1'b0;
  logic rst_n = 1'b0;
  init_arb_if bus();
  init_arb #(.MAX_RETRY(MR)) dut (.c(c), .rst_n(rst_n), .bus(bus));
  always #5 c = ~c;
  int n_chk = 0;
  int n_fail = 0;
  logic [Y-1:0] q1[$], q2[$];
  int stage, src, tries, last;
  logic [Y-1:0] ch1_m, ch2_m;
  bit r1_m, r2_m;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic chk_all();
    logic [1:0] ec;
    ec = (stage == 1 || stage == 2) ? (src == 1 ? CTRL_CH1 : CTRL_CH2) : CTRL_IDLE;
    check("ctrl", bus.ctrl, ec);
    check("chan1", bus.chan1, ch1_m);
    check("chan2", bus.chan2, ch2_m);
    check("fault", bus.fault, stage == 3);
    check("busy", bus.busy, stage != 0);
    check("in1_ready", bus.in1_ready, r1_m);
    check("in2_ready", bus.in2_ready, r2_m);
  endtask
  task automatic model_reset();
    q1.delete();
    q2.delete();
    stage = 0;
    src = 0;
    tries = 0;
    last = 2;
    ch1_m = '0;
    ch2_m = '0;
    r1_m = 0;
    r2_m = 0;
  endtask
  // stage: 0 idle, 1 send, 2 check, 3 drop; src/last: 1 or 2
  task automatic step(input bit a1, input logic [Y-1:0] b1, input bit a2, input logic [Y-1:0] b2, input bit e);
    bit acc1, acc2, p;
    int ns;
    bus.in1_valid = a1;
    bus.in1_data = b1;
    bus.in2_valid = a2;
    bus.in2_data = b2;
    bus.err = e;
    acc1 = a1 && r1_m;
    acc2 = a2 && r2_m;
    p = (stage == 2 && !e) || stage == 3;
    ns = stage;
    case (stage)
      0: if (q1.size() + q2.size() > 0) begin
           src = (q1.size() > 0 && q2.size() > 0) ? 3 - last : (q1.size() > 0 ? 1 : 2);
           ns = 1;
         end
      1: ns = 2;
      2: if (!e) ns = 0;
         else if (tries < MR) begin tries++; ns = 1; end
         else ns = 3;
      default: ns = 0;
    endcase
    if (p) begin
      tries = 0;
      last = src;
      if (src == 1) void'(q1.pop_front());
      else void'(q2.pop_front());
    end
    if (ns == 1) begin
      if (src == 1) ch1_m = q1[0];
      else ch2_m = q2[0];
    end
    if (acc1) q1.push_back(b1);
    if (acc2) q2.push_back(b2);
    r1_m = q1.size() < 2;
    r2_m = q2.size() < 2;
    stage = ns;
    @(posedge c);
    @(negedge c);
    chk_all();
  endtask
  initial begin
    int faults;
    bus.in1_valid = 0;
    bus.in1_data = '0;
    bus.in2_valid = 0;
    bus.in2_data = '0;
    bus.err = 0;
    model_reset();
    repeat (2) @(negedge c);
    chk_all();
    rst_n = 1'b1;
    step(0, '0, 0, '0, 0);
    step(1, 8'hA5, 0, '0, 0);
    repeat (6) step(0, '0, 0, '0, 0);
    step(1, 8'h11, 1, 8'h21, 0);
    step(1, 8'h12, 1, 8'h22, 0);
    repeat (16) step(0, '0, 0, '0, 0);
    faults = 0;
    step(1, 8'h31, 0, '0, 1);
    step(1, 8'h32, 0, '0, 1);
    for (int i = 0; i < 24; i++) begin
      step(0, '0, 0, '0, 1);
      if (bus.fault) faults++;
    end
    check("drop_count", faults, 2);
    repeat (3) step(0, '0, 0, '0, 0);
    step(0, '0, 1, 8'h41, 0);
    for (int i = 0; i < 10; i++) step(0, '0, 0, '0, stage == 2 && tries == 0);
    for (int i = 0; i < 14; i++) step(1, 8'h50 + Y'(i), 0, '0, 0);
    repeat (10) step(0, '0, 0, '0, 0);
    step(1, 8'h61, 1, 8'h71, 0);
    step(1, 8'h62, 1, 8'h72, 0);
    for (int i = 0; i < 10 && stage != 2; i++) step(0, '0, 0, '0, 0);
    check("reached_check", stage, 2);
    #1 rst_n = 1'b0;
    model_reset();
    #1 chk_all();
    @(negedge c);
    chk_all();
    rst_n = 1'b1;
    repeat (6) step(0, '0, 0, '0, 0);
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 1) == 1, Y'($urandom), $urandom_range(0, 1) == 1, Y'($urandom), $urandom_range(0, 3) != 0);
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 2) == 0, Y'($urandom), $urandom_range(0, 2) == 0, Y'($urandom), $urandom_range(0, 4) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
